cal_seq_ctrl: RTL

Sequencing controller for the calendar datapath. It owns the current day-of-week, date and month registers that drive the calendar's day/date/month inputs. It advances them once per day-tick and accepts validated "set date" requests from a host over a valid/ready handshake. A tick and a set request may arrive in the same cycle; the block arbitrates between them so that no tick is silently dropped.

---
 rtl/cal_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cal_seq_ctrl.sv
// cal_seq_ctrl: sequencing controller for the calendar datapath.
// Owns the day-of-week/date/month registers, advances them once per day
// tick and commits host "set date" requests after a one-cycle validity check.
// Ticks that collide with a set request are held pending and applied later.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   day_tick            one-cycle pulse: advance one day
//   set_valid/set_ready host set request handshake (set_ready is combinational)
//   set_day/date/month  requested calendar values
//   set_yr_mod4         requested year mod 4 (used only with LEAP_YEAR_EN)
//   day_o/date_o/month_o current calendar values
//   upd                 one-cycle pulse: outputs changed
//   set_ok/set_err      one-cycle pulse: request committed/rejected
//   tick_lost           sticky: a tick was dropped (cleared by reset only)
//
// Optional feature macro: LEAP_YEAR_EN (tracks year mod 4, Feb has 29 days
// when yr_mod4 == 0).
module cal_seq_ctrl #(
    parameter int RESET_DAY = 0,
    parameter int FEB_DAYS  = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       day_tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [2:0] set_day,
    input  logic [4:0] set_date,
    input  logic [3:0] set_month,
    input  logic [1:0] set_yr_mod4,
    output logic [2:0] day_o,
    output logic [4:0] date_o,
    output logic [3:0] month_o,
    output logic       upd,
    output logic       set_ok,
    output logic       set_err,
    output logic       tick_lost
);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t     state, state_next;
    logic       tick_pend, tick_pend_next;
    logic [2:0] sh_day;
    logic [4:0] sh_date;
    logic [3:0] sh_month;

    logic       accept, do_adv, do_commit, do_reject, drop;
    logic       sh_valid, cur_leap, sh_leap, month_end;
    logic [4:0] cur_len;
    logic [2:0] adv_day;
    logic [4:0] adv_date;
    logic [3:0] adv_month;

    function automatic logic [4:0] mdays(input logic [3:0] m, input logic leap);
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: mdays = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    mdays = 5'd30;
            4'd2:    mdays = leap ? 5'd29 : 5'(FEB_DAYS);
            default: mdays = 5'd0;
        endcase
    endfunction

`ifdef LEAP_YEAR_EN
    logic [1:0] yr_mod4, sh_yr;
    logic       year_wrap;
    assign cur_leap  = (yr_mod4 == 2'd0);
    assign sh_leap   = (sh_yr == 2'd0);
    assign year_wrap = month_end && (month_o == 4'd12);
`else
    logic unused_yr;
    assign cur_leap  = 1'b0;
    assign sh_leap   = 1'b0;
    assign unused_yr = ^set_yr_mod4;
`endif

    assign set_ready = (state == IDLE) && !tick_pend;

    // Shadow validity; an out-of-range month yields mdays 0 and fails here too.
    assign sh_valid = (sh_day <= 3'd6) && (sh_month >= 4'd1) && (sh_month <= 4'd12) &&
                      (sh_date >= 5'd1) && (sh_date <= mdays(sh_month, sh_leap));

    assign cur_len   = mdays(month_o, cur_leap);
    assign month_end = (date_o == cur_len);
    assign adv_day   = (day_o == 3'd6) ? 3'd0 : day_o + 3'd1;
    assign adv_date  = month_end ? 5'd1 : date_o + 5'd1;
    assign adv_month = !month_end ? month_o : ((month_o == 4'd12) ? 4'd1 : month_o + 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        tick_pend_next = tick_pend;
        accept         = 1'b0;
        do_adv         = 1'b0;
        do_commit      = 1'b0;
        do_reject      = 1'b0;
        drop           = 1'b0;
        case (state)
            IDLE: begin
                // A set can only be accepted with no tick pending, so a
                // same-cycle tick is simply deferred behind it.
                if (set_valid && set_ready) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                    if (day_tick) tick_pend_next = 1'b1;
                end else if (day_tick || tick_pend) begin
                    do_adv         = 1'b1;
                    tick_pend_next = tick_pend && day_tick;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (sh_valid) do_commit = 1'b1;
                else          do_reject = 1'b1;
                if (day_tick) begin
                    if (tick_pend) drop = 1'b1;
                    else           tick_pend_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_o     <= 3'(RESET_DAY);
            date_o    <= 5'd1;
            month_o   <= 4'd1;
            sh_day    <= '0;
            sh_date   <= '0;
            sh_month  <= '0;
            tick_pend <= 1'b0;
            tick_lost <= 1'b0;
            upd       <= 1'b0;
            set_ok    <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            upd       <= 1'b0;
            set_ok    <= 1'b0;
            set_err   <= 1'b0;
            tick_pend <= tick_pend_next;
            if (drop) tick_lost <= 1'b1;
            if (accept) begin
                sh_day   <= set_day;
                sh_date  <= set_date;
                sh_month <= set_month;
            end
            if (do_adv) begin
                day_o   <= adv_day;
                date_o  <= adv_date;
                month_o <= adv_month;
                upd     <= 1'b1;
            end
            if (do_commit) begin
                day_o   <= sh_day;
                date_o  <= sh_date;
                month_o <= sh_month;
                upd     <= 1'b1;
                set_ok  <= 1'b1;
            end
            if (do_reject) set_err <= 1'b1;
        end
    end

`ifdef LEAP_YEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yr_mod4 <= '0;
            sh_yr   <= '0;
        end else begin
            if (accept)                 sh_yr   <= set_yr_mod4;
            if (do_commit)              yr_mod4 <= sh_yr;
            else if (do_adv && year_wrap) yr_mod4 <= yr_mod4 + 2'd1;
        end
    end
`endif

endmodule
